// File: rtl/mem_arbiter_if.sv
// Requester and block-RAM side signals of mem_arbiter, grouped as one bus.
// master = requesters plus RAM (testbench/system side), slave = the arbiter.
interface mem_arbiter_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 10
);
    logic                  req0;
    logic                  req1;
    logic                  we0;
    logic                  we1;
    logic [ADDR_WIDTH-1:0] addr0;
    logic [ADDR_WIDTH-1:0] addr1;
    logic [DATA_WIDTH-1:0] wdata0;
    logic [DATA_WIDTH-1:0] wdata1;
    logic                  lock0;
    logic                  lock1;
    logic                  gnt0;
    logic                  gnt1;
    logic                  rvalid0;
    logic                  rvalid1;
    logic [DATA_WIDTH-1:0] rdata;
    logic [DATA_WIDTH-1:0] mem_data;
    logic [ADDR_WIDTH-1:0] mem_read_addr;
    logic [ADDR_WIDTH-1:0] mem_write_addr;
    logic                  mem_we;
    logic [DATA_WIDTH-1:0] mem_q;

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, lock0, lock1, mem_q,
        input  gnt0, gnt1, rvalid0, rvalid1, rdata,
        input  mem_data, mem_read_addr, mem_write_addr, mem_we
    );

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, lock0, lock1, mem_q,
        output gnt0, gnt1, rvalid0, rvalid1, rdata,
        output mem_data, mem_read_addr, mem_write_addr, mem_we
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester arbiter in front of a shared 16x1024 block RAM with lock ownership.
// Define ARB_ROUND_ROBIN_EN for round-robin arbitration in IDLE; default is fixed r0 priority.
module mem_arbiter #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 10,
    parameter int READ_LAT   = 1
) (
    input logic         clk,
    input logic         reset,
    mem_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE,
        OWN0,
        OWN1
    } state_t;

    state_t state;
    state_t state_next;

    logic gnt0;
    logic gnt1;
    logic accept;
    logic cmd_we;
    logic cmd_tag;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [DATA_WIDTH-1:0] cmd_wdata;

    logic                  mem_we_r;
    logic [ADDR_WIDTH-1:0] mem_read_addr_r;
    logic [ADDR_WIDTH-1:0] mem_write_addr_r;
    logic [DATA_WIDTH-1:0] mem_data_r;

    // Stage i holds a read accepted i+1 cycles ago; the last stage lines up with mem_q.
    logic [READ_LAT:0] pipe_valid;
    logic [READ_LAT:0] pipe_tag;

`ifdef ARB_ROUND_ROBIN_EN
    logic ptr;

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr <= 1'b0;
        end else if (gnt0) begin
            ptr <= 1'b1;
        end else if (gnt1) begin
            ptr <= 1'b0;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Grants are gated by reset so nothing is accepted in a reset cycle.
    always_comb begin
        gnt0       = 1'b0;
        gnt1       = 1'b0;
        state_next = state;
        if (!reset) begin
            case (state)
                IDLE: begin
`ifdef ARB_ROUND_ROBIN_EN
                    if (bus.req0 && bus.req1) begin
                        gnt0 = ~ptr;
                        gnt1 = ptr;
                    end else begin
                        gnt0 = bus.req0;
                        gnt1 = bus.req1;
                    end
`else
                    gnt0 = bus.req0;
                    gnt1 = bus.req1 & ~bus.req0;
`endif
                    if (gnt0 && bus.lock0) begin
                        state_next = OWN0;
                    end else if (gnt1 && bus.lock1) begin
                        state_next = OWN1;
                    end
                end
                OWN0: begin
                    gnt0 = bus.req0;
                    if (!bus.lock0) begin
                        state_next = IDLE;
                    end
                end
                OWN1: begin
                    gnt1 = bus.req1;
                    if (!bus.lock1) begin
                        state_next = IDLE;
                    end
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    always_comb begin
        accept    = gnt0 | gnt1;
        cmd_tag   = gnt1;
        cmd_we    = gnt1 ? bus.we1    : bus.we0;
        cmd_addr  = gnt1 ? bus.addr1  : bus.addr0;
        cmd_wdata = gnt1 ? bus.wdata1 : bus.wdata0;
    end

    // Accepted command is presented to the RAM on the following cycle; addresses hold when idle.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_we_r         <= 1'b0;
            mem_read_addr_r  <= '0;
            mem_write_addr_r <= '0;
            mem_data_r       <= '0;
        end else begin
            mem_we_r <= accept & cmd_we;
            if (accept) begin
                if (cmd_we) begin
                    mem_write_addr_r <= cmd_addr;
                    mem_data_r       <= cmd_wdata;
                end else begin
                    mem_read_addr_r <= cmd_addr;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pipe_valid <= '0;
            pipe_tag   <= '0;
        end else begin
            pipe_valid <= {pipe_valid[READ_LAT-1:0], accept & ~cmd_we};
            pipe_tag   <= {pipe_tag[READ_LAT-1:0], cmd_tag};
        end
    end

    assign bus.gnt0           = gnt0;
    assign bus.gnt1           = gnt1;
    assign bus.mem_we         = mem_we_r;
    assign bus.mem_read_addr  = mem_read_addr_r;
    assign bus.mem_write_addr = mem_write_addr_r;
    assign bus.mem_data       = mem_data_r;
    assign bus.rvalid0        = pipe_valid[READ_LAT] & ~pipe_tag[READ_LAT];
    assign bus.rvalid1        = pipe_valid[READ_LAT] & pipe_tag[READ_LAT];
    assign bus.rdata          = pipe_valid[READ_LAT] ? bus.mem_q : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: directed vector table plus randomized traffic checked
// against a transaction-level model (owner, pointer, shadow memory, pending-read queue).
module tb_mem_arbiter;

    localparam int DW = 16;
    localparam int AW = 10;
    localparam int RL = 1;
`ifdef ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    mem_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    mem_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LAT(RL)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    // Block RAM: registered read address, READ_LAT cycles to q, old data on collision.
    logic [DW-1:0] mem_array [0:1023];
    logic [DW-1:0] q_pipe [0:RL-1];

    initial begin
        for (int i = 0; i < 1024; i++) mem_array[i] = '0;
        for (int i = 0; i < RL; i++) q_pipe[i] = '0;
    end

    always @(posedge clk) begin
        q_pipe[0] <= mem_array[bus.mem_read_addr];
        for (int i = 1; i < RL; i++) q_pipe[i] <= q_pipe[i-1];
        if (bus.mem_we) mem_array[bus.mem_write_addr] <= bus.mem_data;
    end

    assign bus.mem_q = q_pipe[RL-1];

    task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: who owns the RAM, whose turn it is, what memory holds, which reads are due.
    typedef struct {
        int          tag;
        logic [DW-1:0] data;
        int          due;
    } rd_t;

    rd_t           pend[$];
    logic [DW-1:0] shadow [0:1023];
    int            owner = -1;
    int            ptr = 0;
    int            cyc = 0;
    bit            model_en = 1'b0;
    logic          e_we = 1'b0;
    logic [AW-1:0] e_wa = '0;
    logic [AW-1:0] e_ra = '0;
    logic [DW-1:0] e_wd = '0;

    initial begin
        logic eg0, eg1, s_rst, erv0, erv1, we, lk;
        logic [DW-1:0] erd;
        int k, a;
        for (int i = 0; i < 1024; i++) shadow[i] = '0;
        forever begin
            @(negedge clk);
            s_rst = reset;
            eg0 = 1'b0;
            eg1 = 1'b0;
            if (!s_rst) begin
                if (owner == 0) eg0 = bus.req0;
                else if (owner == 1) eg1 = bus.req1;
                else if (bus.req0 && bus.req1) begin
                    if (RR && ptr == 1) eg1 = 1'b1;
                    else eg0 = 1'b1;
                end else begin
                    eg0 = bus.req0;
                    eg1 = bus.req1;
                end
            end
            if (model_en) begin
                erv0 = (pend.size() > 0) && (pend[0].due == cyc) && (pend[0].tag == 0);
                erv1 = (pend.size() > 0) && (pend[0].due == cyc) && (pend[0].tag == 1);
                erd  = (erv0 || erv1) ? pend[0].data : '0;
                checkValue("model gnt0", 32'(bus.gnt0), 32'(eg0));
                checkValue("model gnt1", 32'(bus.gnt1), 32'(eg1));
                checkValue("model mem_we", 32'(bus.mem_we), 32'(e_we));
                checkValue("model mem_write_addr", 32'(bus.mem_write_addr), 32'(e_wa));
                checkValue("model mem_read_addr", 32'(bus.mem_read_addr), 32'(e_ra));
                checkValue("model mem_data", 32'(bus.mem_data), 32'(e_wd));
                checkValue("model rvalid0", 32'(bus.rvalid0), 32'(erv0));
                checkValue("model rvalid1", 32'(bus.rvalid1), 32'(erv1));
                checkValue("model rdata", 32'(bus.rdata), 32'(erd));
            end
            @(posedge clk);
            if (s_rst) begin
                owner = -1;
                ptr = 0;
                e_we = 1'b0;
                e_wa = '0;
                e_ra = '0;
                e_wd = '0;
                pend.delete();
                model_en = 1'b1;
            end else begin
                if (pend.size() > 0 && pend[0].due == cyc) void'(pend.pop_front());
                if (eg0 || eg1) begin
                    k  = eg1 ? 1 : 0;
                    we = eg1 ? bus.we1 : bus.we0;
                    a  = eg1 ? int'(bus.addr1) : int'(bus.addr0);
                    lk = eg1 ? bus.lock1 : bus.lock0;
                    e_we = we;
                    if (we) begin
                        e_wa = AW'(a);
                        e_wd = eg1 ? bus.wdata1 : bus.wdata0;
                        shadow[a] = e_wd;
                    end else begin
                        e_ra = AW'(a);
                        pend.push_back('{tag: k, data: shadow[a], due: cyc + 1 + RL});
                    end
                    ptr = 1 - k;
                    if (owner == -1 && lk) owner = k;
                    else if (owner != -1 && !((owner == 0) ? bus.lock0 : bus.lock1)) owner = -1;
                end else begin
                    e_we = 1'b0;
                    if (owner != -1 && !((owner == 0) ? bus.lock0 : bus.lock1)) owner = -1;
                end
            end
            cyc++;
        end
    end

    typedef struct {
        logic          rst;
        logic          req0, we0, lock0;
        logic [AW-1:0] addr0;
        logic [DW-1:0] wdata0;
        logic          req1, we1, lock1;
        logic [AW-1:0] addr1;
        logic [DW-1:0] wdata1;
        logic          g0, g1, rv0, rv1;
        logic [DW-1:0] rdata;
    } vec_t;

    function automatic vec_t mkv(logic rst, logic r0, logic w0, logic l0, int a0, int d0,
                                 logic r1, logic w1, logic l1, int a1, int d1,
                                 logic g0, logic g1, logic rv0, logic rv1, int rd);
        vec_t v;
        v.rst = rst;
        v.req0 = r0; v.we0 = w0; v.lock0 = l0; v.addr0 = AW'(a0); v.wdata0 = DW'(d0);
        v.req1 = r1; v.we1 = w1; v.lock1 = l1; v.addr1 = AW'(a1); v.wdata1 = DW'(d1);
        v.g0 = g0; v.g1 = g1; v.rv0 = rv0; v.rv1 = rv1; v.rdata = DW'(rd);
        return v;
    endfunction

    task automatic applyStimulus(input vec_t v);
        @(posedge clk);
        #1;
        reset = v.rst;
        bus.req0 = v.req0; bus.we0 = v.we0; bus.lock0 = v.lock0;
        bus.addr0 = v.addr0; bus.wdata0 = v.wdata0;
        bus.req1 = v.req1; bus.we1 = v.we1; bus.lock1 = v.lock1;
        bus.addr1 = v.addr1; bus.wdata1 = v.wdata1;
    endtask

    task automatic checkOutput(input vec_t v, input int idx);
        @(negedge clk);
        checkValue($sformatf("row%0d gnt0", idx), 32'(bus.gnt0), 32'(v.g0));
        checkValue($sformatf("row%0d gnt1", idx), 32'(bus.gnt1), 32'(v.g1));
        checkValue($sformatf("row%0d rvalid0", idx), 32'(bus.rvalid0), 32'(v.rv0));
        checkValue($sformatf("row%0d rvalid1", idx), 32'(bus.rvalid1), 32'(v.rv1));
        checkValue($sformatf("row%0d rdata", idx), 32'(bus.rdata), 32'(v.rdata));
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, required self-termination");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_t vecs[30];
        vec_t idle;
        bus.req0 = 1'b0; bus.we0 = 1'b0; bus.lock0 = 1'b0; bus.addr0 = '0; bus.wdata0 = '0;
        bus.req1 = 1'b0; bus.we1 = 1'b0; bus.lock1 = 1'b0; bus.addr1 = '0; bus.wdata1 = '0;

        idle = mkv(0, 0,0,0,0,0, 0,0,0,0,0, 0,0,0,0,0);
        //            rst r0 w0 l0 a0 d0       r1 w1 l1 a1 d1       g0   g1  rv0  rv1  rdata
        vecs[0]  = mkv(1, 0,0,0,0,0,           0,0,0,0,0,           0,   0,  0,   0,   0);
        vecs[1]  = mkv(0, 1,1,0,0,16'h0001,    0,0,0,0,0,           1,   0,  0,   0,   0);
        vecs[2]  = mkv(0, 1,0,0,0,0,           0,0,0,0,0,           1,   0,  0,   0,   0);
        vecs[3]  = idle;
        vecs[4]  = mkv(0, 0,0,0,0,0,           0,0,0,0,0,           0,   0,  1,   0,   16'h0001);
        vecs[5]  = mkv(1, 0,0,0,0,0,           0,0,0,0,0,           0,   0,  0,   0,   0);
        vecs[6]  = mkv(0, 1,0,0,1,0,           1,0,0,2,0,           1,   0,  0,   0,   0);
        vecs[7]  = mkv(0, 1,0,0,1,0,           1,0,0,2,0,           !RR, RR, 0,   0,   0);
        vecs[8]  = mkv(0, 1,0,0,1,0,           1,0,0,2,0,           1,   0,  1,   0,   0);
        vecs[9]  = mkv(0, 1,0,0,1,0,           1,0,0,2,0,           !RR, RR, !RR, RR,  0);
        vecs[10] = mkv(0, 0,0,0,0,0,           1,1,1,5,16'h0005,    0,   1,  1,   0,   0);
        vecs[11] = mkv(0, 1,0,0,5,0,           1,1,1,6,16'h0006,    0,   1,  !RR, RR,  0);
        vecs[12] = mkv(0, 1,0,0,5,0,           1,1,1,7,16'h0007,    0,   1,  0,   0,   0);
        vecs[13] = mkv(0, 1,0,0,5,0,           1,1,1,8,16'h0008,    0,   1,  0,   0,   0);
        vecs[14] = mkv(0, 1,0,0,5,0,           0,0,0,0,0,           0,   0,  0,   0,   0);
        vecs[15] = mkv(0, 1,0,0,5,0,           0,0,0,0,0,           1,   0,  0,   0,   0);
        vecs[16] = idle;
        vecs[17] = mkv(0, 0,0,0,0,0,           0,0,0,0,0,           0,   0,  1,   0,   16'h0005);
        vecs[18] = mkv(0, 1,1,0,3,16'hAAAA,    0,0,0,0,0,           1,   0,  0,   0,   0);
        vecs[19] = mkv(0, 0,0,0,0,0,           1,1,0,4,16'h5555,    0,   1,  0,   0,   0);
        vecs[20] = mkv(0, 1,0,0,3,0,           0,0,0,0,0,           1,   0,  0,   0,   0);
        vecs[21] = mkv(0, 0,0,0,0,0,           1,0,0,4,0,           0,   1,  0,   0,   0);
        vecs[22] = mkv(0, 0,0,0,0,0,           0,0,0,0,0,           0,   0,  1,   0,   16'hAAAA);
        vecs[23] = mkv(0, 0,0,0,0,0,           0,0,0,0,0,           0,   0,  0,   1,   16'h5555);
        vecs[24] = mkv(0, 1,0,0,3,0,           0,0,0,0,0,           1,   0,  0,   0,   0);
        vecs[25] = mkv(1, 0,0,0,0,0,           0,0,0,0,0,           0,   0,  0,   0,   0);
        vecs[26] = idle;
        vecs[27] = mkv(0, 1,0,0,4,0,           0,0,0,0,0,           1,   0,  0,   0,   0);
        vecs[28] = idle;
        vecs[29] = mkv(0, 0,0,0,0,0,           0,0,0,0,0,           0,   0,  1,   0,   16'h5555);

        for (int i = 0; i < 30; i++) begin
            applyStimulus(vecs[i]);
            checkOutput(vecs[i], i);
        end

        // Random traffic over a small address window so reads hit recent writes.
        for (int i = 0; i < 400; i++) begin
            @(posedge clk);
            #1;
            reset      = ($urandom_range(0, 49) == 0);
            bus.req0   = 1'($urandom_range(0, 1));
            bus.req1   = 1'($urandom_range(0, 1));
            bus.we0    = 1'($urandom_range(0, 1));
            bus.we1    = 1'($urandom_range(0, 1));
            bus.lock0  = ($urandom_range(0, 3) == 0);
            bus.lock1  = ($urandom_range(0, 3) == 0);
            bus.addr0  = AW'($urandom_range(0, 15));
            bus.addr1  = AW'($urandom_range(0, 15));
            bus.wdata0 = DW'($urandom);
            bus.wdata1 = DW'($urandom);
        end

        applyStimulus(idle);
        repeat (RL + 3) @(posedge clk);
        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
